// File: rtl/debug_pkg.sv
// debug_pkg: shared opcodes, reply defaults and FSM state encoding for the debugger command front end
package debug_pkg;
  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_STOP  = 8'h53;
  localparam logic [7:0] CMD_NEXT  = 8'h4E;
  localparam logic [7:0] CMD_QUERY = 8'h51;
  localparam logic [7:0] ACK_DEF   = 8'h06;
  localparam logic [7:0] NAK_DEF   = 8'h15;
  typedef enum logic [2:0] {IDLE, GET_ARG, PULSE_HI, PULSE_LO, REPLY} state_t;
endpackage

// File: rtl/debug_pulse_gen.sv
// debug_pulse_gen: emits n pulses of PULSE_W cycles high / GAP_W cycles low; o_done strobes in the final gap cycle
module debug_pulse_gen #(
  parameter int CMD_W = 8,
  parameter int PULSE_W = 2,
  parameter int GAP_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CMD_W-1:0] i_n,
  output logic             o_valid,
  output logic             o_done
);
  localparam int TW = $clog2((PULSE_W > GAP_W ? PULSE_W : GAP_W) + 1);
  logic             active;
  logic [TW-1:0]    tcnt;
  logic [CMD_W-1:0] rem;
  logic             hi_end, lo_end;
  assign hi_end = o_valid && tcnt == TW'(PULSE_W - 1);
  assign lo_end = active && !o_valid && tcnt == TW'(GAP_W - 1);
  assign o_done = lo_end && rem == '0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active  <= 1'b0;
      o_valid <= 1'b0;
      tcnt    <= '0;
      rem     <= '0;
    end else if (i_start) begin
      active  <= 1'b1;
      o_valid <= 1'b1;
      tcnt    <= '0;
      rem     <= i_n;
    end else if (active) begin
      tcnt <= (hi_end || lo_end) ? '0 : tcnt + 1'b1;
      if (hi_end) begin
        o_valid <= 1'b0;
        rem     <= rem - 1'b1;
      end
      if (lo_end) begin
        o_valid <= rem != '0;
        active  <= rem != '0;
      end
    end
  end
endmodule

// File: rtl/debug_cmd_decoder.sv
// debug_cmd_decoder: decodes UART command bytes into continue/step controls and returns ACK/NAK.
// DBG_STEP_COUNTER_EN adds a 16-bit step counter read back by the 'Q' command (MSB then LSB).
module debug_cmd_decoder
  import debug_pkg::*;
#(
  parameter int CMD_W = 8,
  parameter int PULSE_W = 2,
  parameter int GAP_W = 2,
  parameter logic [CMD_W-1:0] ACK_BYTE = CMD_W'(ACK_DEF),
  parameter logic [CMD_W-1:0] NAK_BYTE = CMD_W'(NAK_DEF)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CMD_W-1:0] i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_tx_busy,
  output logic [CMD_W-1:0] o_tx_data,
  output logic             o_tx_start,
  output logic             o_continue,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_drop
);
  state_t state, state_nx;
  logic pg_done, pg_start, rx_idle, rx_arg, tx_go, more;
  logic is_cont, is_stop, is_next, is_query;
  logic [CMD_W-1:0] reply_sel, q_msb, q_lsb;
  assign rx_idle  = i_rx_valid && state == IDLE;
  assign rx_arg   = i_rx_valid && state == GET_ARG;
  assign is_cont  = i_rx_data == CMD_W'(CMD_CONT);
  assign is_stop  = i_rx_data == CMD_W'(CMD_STOP);
  assign is_next  = i_rx_data == CMD_W'(CMD_NEXT);
  assign pg_start = rx_arg && i_rx_data != '0 && !o_continue;
  assign tx_go    = state == REPLY && !i_tx_busy;
  assign reply_sel = !rx_idle ? ACK_BYTE : (is_cont || is_stop) ? ACK_BYTE : is_query ? q_msb : NAK_BYTE;
`ifdef DBG_STEP_COUNTER_EN
  logic [15:0] steps;
  assign is_query = i_rx_data == CMD_W'(CMD_QUERY);
  assign q_msb    = CMD_W'(steps[15:8]);
  assign q_lsb    = CMD_W'(steps[7:0]);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      steps <= '0;
      more  <= 1'b0;
    end else begin
      if (rx_idle && is_stop) steps <= '0;
      else if (state != PULSE_HI && state_nx == PULSE_HI) steps <= steps + 1'b1;
      if (rx_idle && is_query) more <= 1'b1;
      else if (tx_go) more <= 1'b0;
    end
  end
`else
  assign is_query = 1'b0;
  assign q_msb    = '0;
  assign q_lsb    = '0;
  assign more     = 1'b0;
`endif
  debug_pulse_gen #(.CMD_W(CMD_W), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) u_pulse (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (pg_start),
    .i_n     (i_rx_data),
    .o_valid (o_valid),
    .o_done  (pg_done)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:               if (i_rx_valid) state_nx = is_next ? GET_ARG : REPLY;
      GET_ARG:            if (i_rx_valid) state_nx = pg_start ? PULSE_HI : REPLY;
      PULSE_HI, PULSE_LO: state_nx = pg_done ? REPLY : o_valid ? PULSE_HI : PULSE_LO;
      REPLY:              if (tx_go && !more) state_nx = IDLE;
      default:            state_nx = IDLE;
    endcase
  end
  always_comb begin
    o_busy     = state != IDLE && state != GET_ARG;
    o_tx_start = tx_go;
  end
  // a 'Q' reply reloads the LSB once the MSB has been handed to the transmitter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_continue <= 1'b1;
      o_tx_data  <= '0;
      o_drop     <= 1'b0;
    end else begin
      if (rx_idle && is_cont) o_continue <= 1'b1;
      else if (rx_idle && is_stop) o_continue <= 1'b0;
      if (state != REPLY && state_nx == REPLY) o_tx_data <= reply_sel;
      else if (tx_go && more) o_tx_data <= q_lsb;
      o_drop <= i_rx_valid && o_busy;
    end
  end
endmodule
